// File: rtl/uart_tx_fifo.sv
// Byte FIFO that launches stored bytes into uart_TX one frame at a time.
// Optional sticky overflow flag is built only when UART_TX_FIFO_OVERFLOW_EN is defined.
module uart_tx_fifo #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        wrData,
   input  logic                         wrValid,
   output logic                         wrReady,
   output logic [DATA_WIDTH-1:0]        dataTX,
   output logic                         dataTXValid,
   input  logic                         activeTX,
   input  logic                         doneTX,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LAUNCH = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wrPtrReg;
   logic [PTR_W-1:0]      rdPtrReg;
   logic [CNT_W-1:0]      countReg;
   logic [1:0]            stateReg;
   logic [DATA_WIDTH-1:0] dataTXReg;
   logic                  dataTXValidReg;
   logic                  wrEn;
   logic                  popEn;

   assign full        = (countReg == CNT_W'(DEPTH));
   assign empty       = (countReg == '0);
   assign wrReady     = ~full;
   assign count       = countReg;
   assign dataTX      = dataTXReg;
   assign dataTXValid = dataTXValidReg;

   // Full refuses writes even on a pop edge; the doneTX guard keeps a launch
   // from landing on the cycle a frame is still being retired.
   assign wrEn  = wrValid & ~full;
   assign popEn = (stateReg == IDLE) & ~empty & ~activeTX & ~doneTX;

   // Storage has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrPtrReg] <= wrData;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtrReg       <= '0;
         rdPtrReg       <= '0;
         countReg       <= '0;
         stateReg       <= IDLE;
         dataTXReg      <= '0;
         dataTXValidReg <= 1'b0;
      end else begin
         if (wrEn) begin
            wrPtrReg <= wrPtrReg + PTR_W'(1);
         end
         case ({wrEn, popEn})
            2'b10:   countReg <= countReg + CNT_W'(1);
            2'b01:   countReg <= countReg - CNT_W'(1);
            default: countReg <= countReg;
         endcase
         dataTXValidReg <= 1'b0;
         case (stateReg)
            IDLE: begin
               if (popEn) begin
                  dataTXReg      <= mem[rdPtrReg];
                  dataTXValidReg <= 1'b1;
                  rdPtrReg       <= rdPtrReg + PTR_W'(1);
                  stateReg       <= LAUNCH;
               end
            end
            LAUNCH:  stateReg <= WAIT;
            WAIT: begin
               if (doneTX) begin
                  stateReg <= IDLE;
               end
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

`ifdef UART_TX_FIFO_OVERFLOW_EN
   logic overflowReg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflowReg <= 1'b0;
      end else if (wrValid & full) begin
         overflowReg <= 1'b1;
      end
   end

   assign overflow = overflowReg;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo driving a behavioural uart_TX/uart_RX pair.
// Expected bytes are queued at write time and popped when a frame completes.
module tb_uart_tx_fifo;

   localparam int DEPTH        = 16;
   localparam int DW           = 8;
   localparam int CLKS_PER_BIT = 87;
   localparam int FRAME        = 10 * CLKS_PER_BIT;
   localparam int BUDGET       = 30000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] wrData = '0;
   logic          wrValid = 1'b0;
   logic          wrReady;
   logic [DW-1:0] dataTX;
   logic          dataTXValid;
   logic          activeTX;
   logic          doneTX;
   logic [4:0]    count;
   logic          full;
   logic          empty;
   logic          overflow;

   // Behavioural transmitter; it has no reset, like the real uart_TX.
   logic          txActive = 1'b0;
   logic          holdBusy = 1'b0;
   int            txCnt = 0;
   logic [DW-1:0] txShift = '0;
   logic [DW-1:0] rxByte = '0;
   logic          doneReg = 1'b0;

   int            compared = 0;
   int            mismatched = 0;
   int            launches = 0;
   int            frames = 0;
   int            peakCount = 0;
   logic [DW-1:0] sb[$];

   assign activeTX = txActive | holdBusy;
   assign doneTX   = doneReg;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
      .dataTX(dataTX), .dataTXValid(dataTXValid), .activeTX(activeTX), .doneTX(doneTX),
      .count(count), .full(full), .empty(empty), .overflow(overflow)
   );

   always @(posedge clk) begin
      doneReg <= 1'b0;
      if (txActive) begin
         if (txCnt == FRAME - 1) begin
            txActive <= 1'b0;
            doneReg  <= 1'b1;
            rxByte   <= txShift;
         end else begin
            txCnt <= txCnt + 1;
         end
      end else if (dataTXValid) begin
         txActive <= 1'b1;
         txCnt    <= 0;
         txShift  <= dataTX;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr(input logic [DW-1:0] d, input bit expectAccept);
      @(negedge clk);
      wrValid = 1'b1;
      wrData  = d;
      if (expectAccept) sb.push_back(d);
      @(posedge clk);
      #1;
      wrValid = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      bit done = 0;
      for (int i = 0; i < BUDGET && !done; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && empty && !txActive && !doneReg) done = 1;
      end
      check({name, "_drain_timeout"}, int'(done), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic stimulus();
      // 1. reset state
      #1;
      check("rst_count", int'(count), 0);
      check("rst_flags", int'({empty, full, wrReady, dataTXValid, overflow}), 5'b10100);
      check("rst_dataTX", int'(dataTX), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // 2. single byte, launch two edges after the write
      wr(8'h55, 1);
      check("t2_count_after_write", int'(count), 1);
      check("t2_valid_edgeN", int'(dataTXValid), 0);
      @(posedge clk); #1;
      check("t2_valid_edgeN1", int'(dataTXValid), 1);
      check("t2_dataTX", int'(dataTX), 8'h55);
      check("t2_count_after_pop", int'(count), 0);
      @(posedge clk); #1;
      check("t2_valid_one_clock", int'(dataTXValid), 0);
      waitDrain("t2");

      // 3. four consecutive writes
      peakCount = 0;
      wr(8'hA1, 1); wr(8'hA2, 1); wr(8'hA3, 1); wr(8'hA4, 1);
      waitDrain("t3");
      check("t3_peak_count", peakCount, 3);

      // 4. overfill while the transmitter is held busy
      holdBusy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wr(8'hC0 + 8'(i), i < 16);
         if (i == 15) begin
            check("t4_count_16", int'(count), 16);
            check("t4_full_wrReady", int'({full, wrReady}), 2'b10);
         end
      end
      check("t4_count_after_17", int'(count), 16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      check("t4_overflow", int'(overflow), 1);
`else
      check("t4_overflow", int'(overflow), 0);
`endif
      @(negedge clk) holdBusy = 1'b0;
      waitDrain("t4");
`ifdef UART_TX_FIFO_OVERFLOW_EN
      check("t4_overflow_sticky", int'(overflow), 1);
`else
      check("t4_overflow_sticky", int'(overflow), 0);
`endif

      // 5. write on the pop edge keeps count at 1
      holdBusy = 1'b1;
      wr(8'h3B, 1);
      check("t5_count_pre", int'(count), 1);
      @(negedge clk);
      holdBusy = 1'b0;
      wrValid  = 1'b1;
      wrData   = 8'h3C;
      sb.push_back(8'h3C);
      @(posedge clk); #1;
      wrValid = 1'b0;
      check("t5_count_same", int'(count), 1);
      check("t5_launch", int'(dataTXValid), 1);
      check("t5_dataTX", int'(dataTX), 8'h3B);
      waitDrain("t5");

      // 6. reset mid-frame with three bytes queued; only the in-flight byte survives
      peakCount = 0;
      wr(8'h91, 1); wr(8'h92, 0); wr(8'h93, 0); wr(8'h94, 0);
      check("t6_count_queued", int'(count), 3);
      repeat (50) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("t6_rst_count", int'(count), 0);
      check("t6_rst_empty", int'(empty), 1);
      check("t6_tx_still_active", int'(txActive), 1);
      @(posedge clk); #1 rst = 1'b0;
      wr(8'h81, 1);
      waitDrain("t6");

      check("final_sb_empty", sb.size(), 0);
      check("launch_per_frame", launches, frames);
   endtask

   task automatic monitor();
      logic prevValid = 1'b0;
      forever begin
         @(negedge clk);
         if (int'(count) > peakCount) peakCount = int'(count);
         if (dataTXValid) begin
            launches++;
            check("launch_guard", int'({activeTX, doneTX}), 0);
            if (prevValid) check("launch_pulse_width", int'(prevValid), 0);
         end
         prevValid = dataTXValid;
         if (doneReg) begin
            frames++;
            if (sb.size() == 0) begin
               check("frame_unexpected", 1, 0);
            end else begin
               logic [DW-1:0] exp;
               exp = sb.pop_front();
               $display("frame %0d: rx=0x%02h exp=0x%02h", frames, rxByte, exp);
               check("frame_data", int'(rxByte), int'(exp));
            end
         end
      end
   endtask

   initial begin
      fork
         monitor();
         stimulus();
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
